// File: rtl/blood_pkg.sv
// Shared types and constants for the blood monitoring pipeline:
// FSM state encoding, blood-type codes and sample field widths.
`timescale 1ns/1ps
package blood_pkg;

  localparam int PH_W   = 4;
  localparam int TYPE_W = 3;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_ALARM   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  // Codes produced by the upstream detector; B+ has two encodings.
  localparam logic [TYPE_W-1:0] TYPE_AB_POS  = 3'b000;
  localparam logic [TYPE_W-1:0] TYPE_A_POS   = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_B_POS_0 = 3'b100;
  localparam logic [TYPE_W-1:0] TYPE_B_POS_1 = 3'b110;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones. clr together with inc loads 1,
// which lets a run counter restart on the same edge that breaks the old run.
`timescale 1ns/1ps
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE     = W'(1);

  logic [W-1:0] count_r;

  // count register: clear/load-one has priority over saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= inc ? ONE : '0;
    end else if (inc && (count_r != MAX_VAL)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/blood_alarm_controller.sv
// Debounced, latched alarm on runs of abnormal blood samples; needs an
// operator ack and a run of normal samples before monitoring resumes.
`timescale 1ns/1ps
module blood_alarm_controller
  import blood_pkg::*;
#(
  parameter int ALARM_THRESHOLD = 3,
  parameter int CLEAR_THRESHOLD = 2,
  parameter int CNT_W           = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sampleValid,
  input  logic              bloodAbnormality,
  input  logic [PH_W-1:0]   bloodPH,
  input  logic [TYPE_W-1:0] bloodType,
  input  logic              alarmAck,
  output logic              alarm,
  output logic [PH_W-1:0]   alarmPH,
  output logic [TYPE_W-1:0] alarmType,
  output logic [7:0]        alarmCount,
  output logic [1:0]        state
);

  localparam logic [CNT_W:0] ALARM_TH = (CNT_W+1)'(ALARM_THRESHOLD);
  localparam logic [CNT_W:0] CLEAR_TH = (CNT_W+1)'(CLEAR_THRESHOLD);
  localparam logic [CNT_W:0] STEP     = (CNT_W+1)'(1);

  state_t              state_r, next_state_s;
  logic [CNT_W-1:0]    abn_run_r, norm_run_r;
  logic                abn_sample_s, norm_sample_s, abn_hit_s, norm_hit_s;
  logic                enter_alarm_s;
  logic                abn_clr_s, abn_inc_s, norm_clr_s, norm_inc_s;
  logic                alarm_r;
  logic [PH_W-1:0]     alarm_ph_r;
  logic [TYPE_W-1:0]   alarm_type_r;

  assign abn_sample_s  = sampleValid & bloodAbnormality;
  assign norm_sample_s = sampleValid & ~bloodAbnormality;
  assign abn_hit_s     = (({1'b0, abn_run_r} + STEP) == ALARM_TH);
  assign norm_hit_s    = (({1'b0, norm_run_r} + STEP) == CLEAR_TH);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_NORMAL;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state logic; in ALARM samples are ignored and ack wins
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_NORMAL: begin
        if (abn_sample_s) begin
          next_state_s = (ALARM_THRESHOLD == 1) ? ST_ALARM : ST_SUSPECT;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_SUSPECT: begin
        if (abn_sample_s) begin
          next_state_s = abn_hit_s ? ST_ALARM : ST_SUSPECT;
        end else if (norm_sample_s) begin
          next_state_s = ST_NORMAL;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_ALARM: begin
        if (alarmAck) begin
          next_state_s = ST_RECOVER;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_RECOVER: begin
        if (abn_sample_s) begin
          next_state_s = ST_ALARM;
        end else if (norm_sample_s) begin
          next_state_s = norm_hit_s ? ST_NORMAL : ST_RECOVER;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = ST_NORMAL;
    endcase
  end

  // run-counter controls; any ALARM entry leaves abn_run cleared
  always_comb begin
    abn_clr_s     = 1'b0;
    abn_inc_s     = 1'b0;
    norm_clr_s    = 1'b0;
    norm_inc_s    = 1'b0;
    enter_alarm_s = (next_state_s == ST_ALARM) && (state_r != ST_ALARM);
    case (state_r)
      ST_NORMAL: begin
        if (abn_sample_s) begin
          abn_clr_s = 1'b1;
          abn_inc_s = ~enter_alarm_s;
        end else begin
          abn_clr_s = 1'b0;
        end
      end
      ST_SUSPECT: begin
        if (abn_sample_s) begin
          abn_clr_s = abn_hit_s;
          abn_inc_s = ~abn_hit_s;
        end else if (norm_sample_s) begin
          abn_clr_s = 1'b1;
        end else begin
          abn_clr_s = 1'b0;
        end
      end
      ST_ALARM: begin
        if (alarmAck) begin
          norm_clr_s = 1'b1;
        end else begin
          norm_clr_s = 1'b0;
        end
      end
      ST_RECOVER: begin
        if (abn_sample_s) begin
          abn_clr_s = 1'b1;
        end else if (norm_sample_s) begin
          norm_inc_s = 1'b1;
        end else begin
          norm_inc_s = 1'b0;
        end
      end
      default: begin
        abn_clr_s  = 1'b1;
        norm_clr_s = 1'b1;
      end
    endcase
  end

  // alarm level and capture of the triggering sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_r      <= 1'b0;
      alarm_ph_r   <= '0;
      alarm_type_r <= '0;
    end else begin
      alarm_r <= (next_state_s == ST_ALARM);
      if (enter_alarm_s) begin
        alarm_ph_r   <= bloodPH;
        alarm_type_r <= bloodType;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_abn_run (
    .clk(clk), .rst_n(rst_n), .clr(abn_clr_s), .inc(abn_inc_s), .count(abn_run_r)
  );

  sat_counter #(.W(CNT_W)) u_norm_run (
    .clk(clk), .rst_n(rst_n), .clr(norm_clr_s), .inc(norm_inc_s), .count(norm_run_r)
  );

  sat_counter #(.W(8)) u_alarm_count (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(enter_alarm_s), .count(alarmCount)
  );

  assign alarm     = alarm_r;
  assign alarmPH   = alarm_ph_r;
  assign alarmType = alarm_type_r;
  assign state     = state_r;

endmodule

// File: tb/tb_blood_alarm_controller.sv
// Scoreboard bench: the driver queues the hand-computed post-edge outputs
// for each driven cycle; a monitor pops and compares after every rising edge.
`timescale 1ns/1ps
module tb_blood_alarm_controller;
  import blood_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sampleValid = 1'b0;
  logic       bloodAbnormality = 1'b0;
  logic [3:0] bloodPH = 4'd0;
  logic [2:0] bloodType = 3'd0;
  logic       alarmAck = 1'b0;
  logic       alarm;
  logic [3:0] alarmPH;
  logic [2:0] alarmType;
  logic [7:0] alarmCount;
  logic [1:0] state;

  typedef struct {
    logic [17:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  blood_alarm_controller dut (
    .clk(clk), .rst_n(rst_n), .sampleValid(sampleValid),
    .bloodAbnormality(bloodAbnormality), .bloodPH(bloodPH),
    .bloodType(bloodType), .alarmAck(alarmAck), .alarm(alarm),
    .alarmPH(alarmPH), .alarmType(alarmType), .alarmCount(alarmCount),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic void compare(input string name, input logic [17:0] exp);
    logic [17:0] act;
    act = {alarm, alarmPH, alarmType, alarmCount, state};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual alarm=%0b ph=%0d type=%03b count=%0d state=%0d, required alarm=%0b ph=%0d type=%03b count=%0d state=%0d",
               name, act[17], act[16:13], act[12:10], act[9:2], act[1:0],
               exp[17], exp[16:13], exp[12:10], exp[9:2], exp[1:0]);
    end
  endfunction

  // monitor: one queued expectation per rising edge
  always @(posedge clk) begin
    item_t it;
    #2;
    if (sb.size() != 0) begin
      it = sb.pop_front();
      compare(it.name, it.exp);
    end
  end

  task automatic step(input logic v, input logic abn, input logic [3:0] ph,
                      input logic [2:0] ty, input logic ack,
                      input logic ea, input logic [3:0] eph, input logic [2:0] ety,
                      input logic [7:0] ecnt, input logic [1:0] est, input string name);
    item_t it;
    @(negedge clk);
    sampleValid      = v;
    bloodAbnormality = abn;
    bloodPH          = ph;
    bloodType        = ty;
    alarmAck         = ack;
    it.exp  = {ea, eph, ety, ecnt, est};
    it.name = name;
    sb.push_back(it);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int cnt;
    int drain;
    // reset state while rst_n is held low
    #12;
    compare("reset_hold", 18'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 1'b0, 4'd0, TYPE_AB_POS, 1'b0, 1'b0, 4'd0, 3'b000, 8'd0, 2'd0, "reset_idle");

    // run broken by a normal sample
    step(1'b1, 1'b1, 4'd6, TYPE_AB_POS, 1'b0, 1'b0, 4'd0, 3'b000, 8'd0, 2'd1, "brk_abn1");
    step(1'b1, 1'b1, 4'd6, TYPE_AB_POS, 1'b0, 1'b0, 4'd0, 3'b000, 8'd0, 2'd1, "brk_abn2");
    step(1'b1, 1'b0, 4'd7, TYPE_AB_POS, 1'b0, 1'b0, 4'd0, 3'b000, 8'd0, 2'd0, "brk_norm");

    // alarm raised and held
    step(1'b1, 1'b1, 4'd6, TYPE_AB_POS,  1'b0, 1'b0, 4'd0, 3'b000, 8'd0, 2'd1, "raise_1");
    step(1'b1, 1'b1, 4'd6, TYPE_AB_POS,  1'b0, 1'b0, 4'd0, 3'b000, 8'd0, 2'd1, "raise_2");
    step(1'b1, 1'b1, 4'd5, TYPE_B_POS_0, 1'b0, 1'b1, 4'd5, 3'b100, 8'd1, 2'd2, "raise_3");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 4'd9, TYPE_A_POS, 1'b0, 1'b1, 4'd5, 3'b100, 8'd1, 2'd2, "hold_abn");
    step(1'b0, 1'b0, 4'd0, TYPE_AB_POS, 1'b0, 1'b1, 4'd5, 3'b100, 8'd1, 2'd2, "hold_idle");

    // ack and recovery
    step(1'b0, 1'b0, 4'd0, TYPE_AB_POS, 1'b1, 1'b0, 4'd5, 3'b100, 8'd1, 2'd3, "ack");
    step(1'b1, 1'b0, 4'd7, TYPE_A_POS,  1'b0, 1'b0, 4'd5, 3'b100, 8'd1, 2'd3, "rec_norm1");
    step(1'b1, 1'b0, 4'd7, TYPE_A_POS,  1'b0, 1'b0, 4'd5, 3'b100, 8'd1, 2'd0, "rec_norm2");

    // ack ignored outside ALARM
    step(1'b1, 1'b1, 4'd6, TYPE_AB_POS, 1'b1, 1'b0, 4'd5, 3'b100, 8'd1, 2'd1, "ack_in_normal");
    step(1'b1, 1'b0, 4'd7, TYPE_AB_POS, 1'b0, 1'b0, 4'd5, 3'b100, 8'd1, 2'd0, "susp_to_norm");

    // suspect run with a gap, then re-alarm from RECOVER
    step(1'b1, 1'b1, 4'd3, TYPE_A_POS,   1'b0, 1'b0, 4'd5, 3'b100, 8'd1, 2'd1, "gap_abn1");
    step(1'b0, 1'b0, 4'd0, TYPE_AB_POS,  1'b0, 1'b0, 4'd5, 3'b100, 8'd1, 2'd1, "gap_idle");
    step(1'b1, 1'b1, 4'd3, TYPE_A_POS,   1'b0, 1'b0, 4'd5, 3'b100, 8'd1, 2'd1, "gap_abn2");
    step(1'b1, 1'b1, 4'd3, TYPE_A_POS,   1'b0, 1'b1, 4'd3, 3'b010, 8'd2, 2'd2, "gap_abn3");
    step(1'b0, 1'b0, 4'd0, TYPE_AB_POS,  1'b1, 1'b0, 4'd3, 3'b010, 8'd2, 2'd3, "ack2");
    step(1'b1, 1'b0, 4'd7, TYPE_B_POS_1, 1'b0, 1'b0, 4'd3, 3'b010, 8'd2, 2'd3, "rec_norm");
    step(1'b1, 1'b1, 4'd5, TYPE_B_POS_1, 1'b0, 1'b1, 4'd5, 3'b110, 8'd3, 2'd2, "realarm");

    // ack and a valid abnormal sample in the same cycle
    step(1'b1, 1'b1, 4'd1, TYPE_AB_POS, 1'b1, 1'b0, 4'd5, 3'b110, 8'd3, 2'd3, "ack_and_sample");
    step(1'b0, 1'b0, 4'd0, TYPE_AB_POS, 1'b0, 1'b0, 4'd5, 3'b110, 8'd3, 2'd3, "rec_idle");
    step(1'b1, 1'b0, 4'd7, TYPE_AB_POS, 1'b0, 1'b0, 4'd5, 3'b110, 8'd3, 2'd3, "normrun_reset");
    step(1'b1, 1'b0, 4'd7, TYPE_AB_POS, 1'b0, 1'b0, 4'd5, 3'b110, 8'd3, 2'd0, "rec_done");

    // reset mid-alarm
    step(1'b1, 1'b1, 4'd8, TYPE_B_POS_0, 1'b0, 1'b0, 4'd5, 3'b110, 8'd3, 2'd1, "pre_rst1");
    step(1'b1, 1'b1, 4'd8, TYPE_B_POS_0, 1'b0, 1'b0, 4'd5, 3'b110, 8'd3, 2'd1, "pre_rst2");
    step(1'b1, 1'b1, 4'd8, TYPE_B_POS_0, 1'b0, 1'b1, 4'd8, 3'b100, 8'd4, 2'd2, "pre_rst3");
    step(1'b0, 1'b0, 4'd0, TYPE_AB_POS,  1'b0, 1'b1, 4'd8, 3'b100, 8'd4, 2'd2, "pre_rst_idle");
    drain = 0;
    while (sb.size() != 0 && drain < 10) begin
      @(posedge clk);
      #3;
      drain++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: actual %0d pending, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 compare("async_reset", 18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 4'd0, TYPE_AB_POS, 1'b0, 1'b0, 4'd0, 3'b000, 8'd0, 2'd0, "post_reset");

    // saturation of alarmCount
    step(1'b1, 1'b1, 4'd2, TYPE_AB_POS, 1'b0, 1'b0, 4'd0, 3'b000, 8'd0, 2'd1, "sat_abn1");
    step(1'b1, 1'b1, 4'd2, TYPE_AB_POS, 1'b0, 1'b0, 4'd0, 3'b000, 8'd0, 2'd1, "sat_abn2");
    step(1'b1, 1'b1, 4'd2, TYPE_AB_POS, 1'b0, 1'b1, 4'd2, 3'b000, 8'd1, 2'd2, "sat_abn3");
    for (int i = 2; i <= 257; i++) begin
      cnt = (i - 1 > 255) ? 255 : i - 1;
      step(1'b0, 1'b0, 4'd0, TYPE_AB_POS, 1'b1, 1'b0, 4'd2, 3'b000, cnt[7:0], 2'd3, "sat_ack");
      cnt = (i > 255) ? 255 : i;
      step(1'b1, 1'b1, 4'd2, TYPE_AB_POS, 1'b0, 1'b1, 4'd2, 3'b000, cnt[7:0], 2'd2, "sat_alarm");
    end
    step(1'b0, 1'b0, 4'd0, TYPE_AB_POS, 1'b0, 1'b1, 4'd2, 3'b000, 8'd255, 2'd2, "sat_final");

    @(posedge clk);
    #4;
    @(posedge clk);
    #4;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL end_drain: actual %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
